// File: rtl/fp_pkg.sv
// Shared floating-point helpers: operand classes, format constants and
// width-independent classification used by the multiplier and adder.
package fp_pkg;

    typedef enum logic [2:0] {
        ZERO,
        SUB,
        NORM,
        INF,
        NAN
    } fp_class_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_emax(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Canonical quiet NaN in the low fp_width() bits: {0, all-ones exp, 1, 0...}
    function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
        logic [127:0] q;
        q = '0;
        for (int i = 0; i < exp_w; i++) begin
            q[man_w + i] = 1'b1;
        end
        q[man_w - 1] = 1'b1;
        return q;
    endfunction

    function automatic fp_class_t fp_classify(input logic exp_zero,
                                              input logic exp_max,
                                              input logic frac_zero);
        if (exp_zero) begin
            return frac_zero ? ZERO : SUB;
        end
        if (exp_max) begin
            return frac_zero ? INF : NAN;
        end
        return NORM;
    endfunction

    // Subnormal operands are flushed to zero before any arithmetic.
    function automatic fp_class_t fp_ftz(input fp_class_t c);
        return (c == SUB) ? ZERO : c;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even and pack of a normalised significand, with
// overflow to infinity and flush-to-zero underflow.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int N     = 1 + EXP_W + MAN_W,
    localparam int EW    = EXP_W + 2
) (
    input  logic                 i_sign,
    input  logic signed [EW-1:0] i_exp,
    input  logic [MAN_W:0]       i_mant,
    input  logic                 i_guard,
    input  logic                 i_sticky,
    output logic [N-1:0]         o_result,
    output logic                 o_overflow,
    output logic                 o_underflow
);

    localparam int                   EMAX   = fp_emax(EXP_W);
    localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);

    logic                 w_up;
    logic [MAN_W+1:0]     w_sum;
    logic                 w_carry;
    logic signed [EW-1:0] w_exp_f;

    assign w_up    = i_guard & (i_sticky | i_mant[0]);
    assign w_sum   = {1'b0, i_mant} + {{(MAN_W + 1){1'b0}}, w_up};
    assign w_carry = w_sum[MAN_W+1];
    // A carry-out leaves the fraction field at zero, so only the exponent moves.
    assign w_exp_f = i_exp + $signed({{(EW - 1){1'b0}}, w_carry});

    always_comb begin
        o_overflow  = 1'b0;
        o_underflow = 1'b0;
        o_result    = {i_sign, w_exp_f[EXP_W-1:0], w_sum[MAN_W-1:0]};
        if (w_exp_f >= EMAX_S) begin
            o_overflow = 1'b1;
            o_result   = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_exp_f[EW-1] || (w_exp_f == '0)) begin
            o_underflow = 1'b1;
            o_result    = {i_sign, {(N - 1){1'b0}}};
        end
    end

endmodule

// File: rtl/fp_multiplier_pipe.sv
// Three-stage floating-point multiplier: capture/classify, multiply,
// normalise/round/pack with special-value handling and exception flags.
module fp_multiplier_pipe
    import fp_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int N     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         in_valid,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic         underflow,
    output logic         invalid
);

    localparam int                   BIAS      = fp_bias(EXP_W);
    localparam int                   PW        = 2 * MAN_W + 2;
    localparam int                   EW        = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS_S    = EW'(BIAS);
    localparam logic [127:0]         QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
    localparam logic [N-1:0]         QNAN      = QNAN_WIDE[N-1:0];

    // ---------------- Stage 1: operand capture ----------------
    logic         r1_valid;
    logic [N-1:0] r1_a;
    logic [N-1:0] r1_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_valid <= 1'b0;
            r1_a     <= '0;
            r1_b     <= '0;
        end else if (enable) begin
            r1_valid <= in_valid;
            r1_a     <= A;
            r1_b     <= B;
        end
    end

    logic [N-1:0]     w_op  [2];
    logic [EXP_W-1:0] w_exp [2];
    logic [MAN_W:0]   w_sig [2];
    fp_class_t        w_cls [2];

    assign w_op[0] = r1_a;
    assign w_op[1] = r1_b;

    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
        assign w_exp[gi] = w_op[gi][N-2:MAN_W];
        assign w_sig[gi] = {1'b1, w_op[gi][MAN_W-1:0]};
        assign w_cls[gi] = fp_ftz(fp_classify(w_exp[gi] == '0,
                                              w_exp[gi] == {EXP_W{1'b1}},
                                              w_op[gi][MAN_W-1:0] == '0));
    end

    // ---------------- Stage 2: sign, product, exponent ----------------
    logic [PW-1:0]        w_prod;
    logic signed [EW-1:0] w_exp_sum;

    assign w_prod    = {{(MAN_W + 1){1'b0}}, w_sig[0]} * {{(MAN_W + 1){1'b0}}, w_sig[1]};
    assign w_exp_sum = $signed({2'b00, w_exp[0]}) + $signed({2'b00, w_exp[1]}) - BIAS_S;

    logic                 r2_valid;
    logic                 r2_sign;
    logic [PW-1:0]        r2_prod;
    logic signed [EW-1:0] r2_exp;
    fp_class_t            r2_cls_a;
    fp_class_t            r2_cls_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r2_valid <= 1'b0;
            r2_sign  <= 1'b0;
            r2_prod  <= '0;
            r2_exp   <= '0;
            r2_cls_a <= ZERO;
            r2_cls_b <= ZERO;
        end else if (enable) begin
            r2_valid <= r1_valid;
            r2_sign  <= r1_a[N-1] ^ r1_b[N-1];
            r2_prod  <= w_prod;
            r2_exp   <= w_exp_sum;
            r2_cls_a <= w_cls[0];
            r2_cls_b <= w_cls[1];
        end
    end

    // ---------------- Stage 3: normalise, round, specials ----------------
    logic                 w_norm_hi;
    logic [MAN_W:0]       w_mant;
    logic                 w_guard;
    logic                 w_sticky;
    logic signed [EW-1:0] w_exp_n;
    logic [N-1:0]         w_fin_res;
    logic                 w_fin_ovf;
    logic                 w_fin_unf;

    // Product of two [1,2) significands lies in [1,4): at most one right shift.
    assign w_norm_hi = r2_prod[PW-1];
    assign w_mant    = w_norm_hi ? r2_prod[PW-1:MAN_W+1] : r2_prod[PW-2:MAN_W];
    assign w_guard   = w_norm_hi ? r2_prod[MAN_W] : r2_prod[MAN_W-1];
    assign w_sticky  = w_norm_hi ? (|r2_prod[MAN_W-1:0]) : (|r2_prod[MAN_W-2:0]);
    assign w_exp_n   = r2_exp + $signed({{(EW - 1){1'b0}}, w_norm_hi});

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .i_sign      (r2_sign),
        .i_exp       (w_exp_n),
        .i_mant      (w_mant),
        .i_guard     (w_guard),
        .i_sticky    (w_sticky),
        .o_result    (w_fin_res),
        .o_overflow  (w_fin_ovf),
        .o_underflow (w_fin_unf)
    );

    logic         w_any_nan;
    logic         w_any_inf;
    logic         w_any_zero;
    logic [N-1:0] w_res;
    logic         w_ovf;
    logic         w_unf;
    logic         w_inv;

    assign w_any_nan  = (r2_cls_a == NAN) || (r2_cls_b == NAN);
    assign w_any_inf  = (r2_cls_a == INF) || (r2_cls_b == INF);
    assign w_any_zero = (r2_cls_a == ZERO) || (r2_cls_b == ZERO);

    always_comb begin
        w_res = w_fin_res;
        w_ovf = w_fin_ovf;
        w_unf = w_fin_unf;
        w_inv = 1'b0;
        if (w_any_nan || (w_any_zero && w_any_inf)) begin
            w_res = QNAN;
            w_ovf = 1'b0;
            w_unf = 1'b0;
            w_inv = 1'b1;
        end else if (w_any_inf) begin
            w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_ovf = 1'b0;
            w_unf = 1'b0;
        end else if (w_any_zero) begin
            w_res = {r2_sign, {(N - 1){1'b0}}};
            w_ovf = 1'b0;
            w_unf = 1'b0;
        end
    end

    logic         r_out_valid;
    logic [N-1:0] r_result;
    logic         r_overflow;
    logic         r_underflow;
    logic         r_invalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_invalid   <= 1'b0;
        end else if (enable) begin
            r_out_valid <= r2_valid;
            r_result    <= w_res;
            r_overflow  <= w_ovf;
            r_underflow <= w_unf;
            r_invalid   <= w_inv;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign invalid   = r_invalid;

endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Directed-vector bench for the single-precision configuration of the
// pipelined multiplier; a monitor scores every enabled output against a queue.
module tb_fp_multiplier_pipe;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        invalid;

    fp_multiplier_pipe #(
        .EXP_W (8),
        .MAN_W (23)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .invalid   (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    logic [34:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Flags are packed {overflow, underflow, invalid}.
    localparam int NV = 19;
    logic [31:0] va [NV] = '{32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h3F800001,
                             32'h3F800003, 32'h3FFFFFFE, 32'h7F000000, 32'h7F000000,
                             32'h7F000000, 32'h00800000, 32'h00800000, 32'h00000000,
                             32'h7FC00000, 32'hFFC00001, 32'h80000000, 32'h00000001,
                             32'h80000001, 32'hFF800000, 32'hFF800000};
    logic [31:0] vb [NV] = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h3FC00000,
                             32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'h3F800000,
                             32'h40000000, 32'h00800000, 32'h3F000000, 32'h7F800000,
                             32'h3F800000, 32'h7F800000, 32'h3F800000, 32'h3F800000,
                             32'h3F800000, 32'h40000000, 32'h7F800000};
    logic [31:0] vr [NV] = '{32'h40400000, 32'hC0C00000, 32'h3F800002, 32'h3FC00002,
                             32'h3FC00004, 32'h40000000, 32'h7F800000, 32'h7F000000,
                             32'h7F800000, 32'h00000000, 32'h00000000, 32'h7FC00000,
                             32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'h00000000,
                             32'h80000000, 32'hFF800000, 32'hFF800000};
    logic [2:0]  vf [NV] = '{3'b000, 3'b000, 3'b000, 3'b000,
                             3'b000, 3'b000, 3'b100, 3'b000,
                             3'b100, 3'b010, 3'b010, 3'b001,
                             3'b001, 3'b001, 3'b000, 3'b000,
                             3'b000, 3'b000, 3'b000};

    task automatic issue(input int idx);
        A        = va[idx];
        B        = vb[idx];
        in_valid = 1'b1;
        exp_q.push_back({vr[idx], vf[idx]});
        @(negedge clk);
    endtask

    // Monitor: a new result exists only after an enabled, non-reset edge.
    always @(posedge clk) begin
        logic        en_s;
        logic        rst_s;
        logic [34:0] e;
        en_s  = enable;
        rst_s = reset;
        #2;
        if (!rst_s && !reset && en_s && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("extra_result", {63'd0, out_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                n_out++;
                chk($sformatf("res%0d", n_out), {32'd0, result}, {32'd0, e[34:3]});
                chk($sformatf("flags%0d", n_out), {61'd0, overflow, underflow, invalid},
                    {61'd0, e[2:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        #12;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_flags", {61'd0, overflow, underflow, invalid}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Latency: exactly three enabled edges from in_valid to out_valid.
        @(negedge clk);
        A        = va[0];
        B        = vb[0];
        in_valid = 1'b1;
        exp_q.push_back({vr[0], vf[0]});
        @(posedge clk);
        #1;
        chk("lat_edge1", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("lat_edge2", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk("lat_edge3", {63'd0, out_valid}, 64'd1);
        @(negedge clk);

        // Directed vectors, back to back.
        for (int i = 0; i < NV; i++) begin
            issue(i);
        end
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("drain_vectors", 64'(exp_q.size()), 64'd0);

        // Stream with a two-cycle stall once the first result is out.
        issue(2);
        issue(6);
        issue(11);
        enable   = 1'b0;
        A        = 32'h7F800000;
        B        = 32'h7F800000;
        in_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_result", {32'd0, result}, {32'd0, vr[2]});
            chk("stall_flags", {61'd0, overflow, underflow, invalid}, {61'd0, vf[2]});
        end
        @(negedge clk);
        enable = 1'b1;
        issue(1);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("drain_stream", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset between edges with two operations in flight.
        issue(6);
        issue(0);
        issue(1);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_result", {32'd0, result}, 64'd0);
        chk("arst_flags", {61'd0, overflow, underflow, invalid}, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("post_rst_idle", {63'd0, out_valid}, 64'd0);
        end
        @(negedge clk);
        issue(3);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("drain_post_rst", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_multiplier_pipe.md
Name: fp_multiplier_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point multiplier; successor to the single-cycle 32-bit fpMultiplier.
- Adds: generic exponent/mantissa widths, valid tagging through a 3-stage pipeline, stall via enable, round-to-nearest-even, special-value handling (zero/inf/NaN), and separate overflow/underflow/invalid flags.
- Sits in the arithmetic datapath next to the adder; feeds the result register file / accumulator.

Parameters:
- EXP_W, 8, exponent field width (8 = single, 11 = double, 5 = half).
- MAN_W, 23, stored fraction width (hidden bit excluded).
- Derived localparams: N = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1; EMAX = 2^EXP_W-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all pipeline state.
- enable  in  1  global advance; 0 freezes every pipeline register (stall).
- in_valid  in  1  A/B carry a valid operand pair this cycle.
- A  in  N  operand A {sign, exp, frac}.
- B  in  N  operand B.
- out_valid  out  1  result/flags are valid.
- result  out  N  rounded product.
- overflow  out  1  result rounded to ±inf from finite inputs.
- underflow  out  1  nonzero exact product flushed to ±0.
- invalid  out  1  0 × inf, or any NaN operand.

Behaviour:
- Reset (async): all stage regs, out_valid, result, overflow, underflow and invalid = 0, effective immediately. A reset mid-flight discards all in-flight operations; no partial output.
- Pipeline (one stage advances only when enable=1):
  - S1: register A, B and in_valid; unpack fields; classify each operand as ZERO, SUB, NORM, INF or NAN.
  - S2: compute sign = sA^sB. Compute the (2·MAN_W+2)-bit mantissa product of {1,frac}. Compute the signed (EXP_W+2)-bit exponent eA+eB-BIAS.
  - S3: normalise (if the product MSB is set, shift right 1 and increment the exponent), round RNE, pack, set flags, and register outputs.
- Latency: exactly 3 enabled cycles from in_valid to out_valid. Throughput: 1 per enabled cycle.
- enable=0 holds all registers, including the outputs. in_valid is ignored while stalled.
- Bubbles: in_valid=0 propagates out_valid=0. Result and flags of a bubble are don't-care; the bench must not check them.
- Subnormal inputs: flushed to zero (FTZ) before the multiply. Sign is kept.
- Rounding (RNE): guard = first dropped bit; sticky = OR of the remaining dropped bits; round up if guard & (sticky | lsb). A mantissa carry-out renormalises and increments the exponent.
- Special cases, in priority order:
  1. Any NAN operand → canonical qNaN {0, EMAX, 1, 0...}; invalid=1.
  2. ZERO × INF → canonical qNaN; invalid=1.
  3. INF × (NORM or INF) → {sign, EMAX, 0}.
  4. ZERO involved → {sign, 0, 0} (signed zero); no flags.
- Finite result, final exponent ≥ EMAX → {sign, EMAX, 0}; overflow=1.
- Finite result, final exponent ≤ 0 → {sign, 0, 0}; underflow=1. No subnormal outputs.
- At most one of overflow/underflow/invalid is set per result.

Decomposition:
- Shared package fp_pkg:
  - fp_class_t enum {ZERO, SUB, NORM, INF, NAN};
  - functions for bias/EMAX from EXP_W;
  - canonical-qNaN constant builder;
  - field-slice helpers.
- Sub-module fp_round_pack: takes sign, signed exponent, normalised mantissa + guard/sticky; returns packed result + overflow/underflow. Reused by the adder.

Test Plan (EXP_W=8, MAN_W=23):
- Basic and latency: A=0x3FC00000, B=0x40000000, in_valid=1, enable=1 → 3 cycles later result=0x40400000, out_valid=1, all flags 0.
- Sign and rounding: C0000000×40400000 → C0C00000. Rounding: 3F800001×3F800001 → 3F800002.
- Overflow/underflow: 7F000000×7F000000 → 7F800000, overflow=1. Underflow: 00800000×00800000 → 00000000, underflow=1.
- Specials:
  - 00000000×7F800000 → 7FC00000, invalid=1.
  - 7FC00000×3F800000 → 7FC00000, invalid=1.
  - 80000000×3F800000 → 80000000.
  - Subnormal 00000001×3F800000 → 00000000, no flags.
- Stall/stream: issue 4 back-to-back ops, drop enable for 2 cycles mid-stream → outputs held during the stall, all 4 results emerge in order, none dropped or duplicated.
- Async reset: assert reset between clock edges with 2 ops in flight → out_valid and all outputs 0 immediately; after release, no stale results appear.
